yoshi_ghost_collision: RTL and testbench

//  Sits downstream of the ghost sprite blocks (ghost_top etc.) and the yoshi sprite block.

---
 rtl/yoshi_ghost_collision_if.sv | 27 ++
 rtl/yoshi_ghost_collision.sv | 147 ++++++++++++++
 tb/tb_yoshi_ghost_collision.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/yoshi_ghost_collision_if.sv
// Pixel-stream inputs and game-state outputs shared between the sprite pipeline
// and the yoshi/ghost collision block.
interface yoshi_ghost_collision_if #(
  parameter int N_GHOSTS = 3
);
  logic [9:0]          i_x;
  logic [9:0]          i_y;
  logic                i_yoshi_on;
  logic [N_GHOSTS-1:0] i_ghost_on;
  logic                i_restart;
  logic [2:0]          o_lives;
  logic                o_hit_tick;
  logic [N_GHOSTS-1:0] o_hit_ghost;
  logic                o_yoshi_visible;
  logic                o_ghosts_freeze;
  logic                o_game_over;

  modport master (
    output i_x, i_y, i_yoshi_on, i_ghost_on, i_restart,
    input  o_lives, o_hit_tick, o_hit_ghost, o_yoshi_visible, o_ghosts_freeze, o_game_over
  );

  modport slave (
    input  i_x, i_y, i_yoshi_on, i_ghost_on, i_restart,
    output o_lives, o_hit_tick, o_hit_ghost, o_yoshi_visible, o_ghosts_freeze, o_game_over
  );
endinterface

// File: rtl/yoshi_ghost_collision.sv
// Per-frame yoshi/ghost overlap measurement feeding a lives / invulnerability /
// game-over state machine; every output is registered.
module yoshi_ghost_collision #(
  parameter int N_GHOSTS      = 3,
  parameter int LIVES         = 3,
  parameter int OVERLAP_MIN   = 16,
  parameter int INVULN_FRAMES = 120,
  parameter int FLASH_FRAMES  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  yoshi_ghost_collision_if.slave  bus
);

  typedef enum logic [1:0] {S_PLAY, S_HIT, S_OVER} state_t;

  localparam int                FL_B       = $clog2(FLASH_FRAMES);
  localparam logic [2:0]        LIVES_INIT = 3'(LIVES);
  localparam logic [7:0]        INV_INIT   = 8'(INVULN_FRAMES);
  localparam logic [8:0]        OVL_MIN    = 9'(OVERLAP_MIN);
  localparam logic [8:0]        OVL_MAX    = 9'h1FF;

  state_t              r_state;
  logic [9:0]          r_y_prev;
  logic [8:0]          r_ovl_cnt;
  logic [N_GHOSTS-1:0] r_ov_mask;
  logic [2:0]          r_lives;
  logic [7:0]          r_inv_cnt;
  logic [7:0]          r_flash_cnt;
  logic                r_hit_tick;
  logic [N_GHOSTS-1:0] r_hit_ghost;
  logic                r_yoshi_visible;
  logic                r_ghosts_freeze;
  logic                r_game_over;

  state_t              w_state_nxt;
  logic [2:0]          w_lives_nxt;
  logic [7:0]          w_inv_nxt;
  logic [7:0]          w_flash_nxt;
  logic                w_hit_tick_nxt;
  logic [N_GHOSTS-1:0] w_hit_ghost_nxt;
  logic                w_frame_end;
  logic                w_ovl_pix;
  logic                w_hit;

  assign w_frame_end = (bus.i_y == 10'd480) && (r_y_prev != 10'd480);
  assign w_ovl_pix   = (bus.i_x < 10'd640) && (bus.i_y < 10'd480) &&
                       bus.i_yoshi_on && (|bus.i_ghost_on);
  assign w_hit       = w_frame_end && (r_ovl_cnt >= OVL_MIN);

  // Overlap accumulator: frame end and restart both clear, and win over counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_y_prev  <= '0;
      r_ovl_cnt <= '0;
      r_ov_mask <= '0;
    end else begin
      r_y_prev <= bus.i_y;
      if (bus.i_restart || w_frame_end) begin
        r_ovl_cnt <= '0;
        r_ov_mask <= '0;
      end else if (w_ovl_pix) begin
        if (r_ovl_cnt != OVL_MAX) r_ovl_cnt <= r_ovl_cnt + 9'd1;
        r_ov_mask <= r_ov_mask | bus.i_ghost_on;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_lives_nxt     = r_lives;
    w_inv_nxt       = r_inv_cnt;
    w_flash_nxt     = r_flash_cnt;
    w_hit_tick_nxt  = 1'b0;
    w_hit_ghost_nxt = r_hit_ghost;
    if (bus.i_restart) begin
      w_state_nxt     = S_PLAY;
      w_lives_nxt     = LIVES_INIT;
      w_inv_nxt       = '0;
      w_flash_nxt     = '0;
      w_hit_ghost_nxt = '0;
    end else if (w_frame_end) begin
      case (r_state)
        S_PLAY: begin
          if (w_hit) begin
            w_hit_tick_nxt  = 1'b1;
            w_hit_ghost_nxt = r_ov_mask;
            if (r_lives <= 3'd1) begin
              w_state_nxt = S_OVER;
              w_lives_nxt = '0;
            end else begin
              w_state_nxt = S_HIT;
              w_lives_nxt = r_lives - 3'd1;
              w_inv_nxt   = INV_INIT;
              w_flash_nxt = '0;
            end
          end
        end
        // Overlap seen in the frame that ends invulnerability is deliberately dropped
        S_HIT: begin
          if (r_inv_cnt <= 8'd1) begin
            w_state_nxt = S_PLAY;
            w_inv_nxt   = '0;
            w_flash_nxt = '0;
          end else begin
            w_inv_nxt   = r_inv_cnt - 8'd1;
            w_flash_nxt = r_flash_cnt + 8'd1;
          end
        end
        S_OVER:  w_lives_nxt = '0;
        default: w_state_nxt = S_PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_PLAY;
      r_lives         <= LIVES_INIT;
      r_inv_cnt       <= '0;
      r_flash_cnt     <= '0;
      r_hit_tick      <= 1'b0;
      r_hit_ghost     <= '0;
      r_yoshi_visible <= 1'b1;
      r_ghosts_freeze <= 1'b0;
      r_game_over     <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_lives         <= w_lives_nxt;
      r_inv_cnt       <= w_inv_nxt;
      r_flash_cnt     <= w_flash_nxt;
      r_hit_tick      <= w_hit_tick_nxt;
      r_hit_ghost     <= w_hit_ghost_nxt;
      r_yoshi_visible <= (w_state_nxt == S_HIT) ? ~w_flash_nxt[FL_B] : 1'b1;
      r_ghosts_freeze <= (w_state_nxt == S_OVER);
      r_game_over     <= (w_state_nxt == S_OVER);
    end
  end

  assign bus.o_lives         = r_lives;
  assign bus.o_hit_tick      = r_hit_tick;
  assign bus.o_hit_ghost     = r_hit_ghost;
  assign bus.o_yoshi_visible = r_yoshi_visible;
  assign bus.o_ghosts_freeze = r_ghosts_freeze;
  assign bus.o_game_over     = r_game_over;

endmodule

// File: tb/tb_yoshi_ghost_collision.sv
// Directed bench for yoshi_ghost_collision: expected hits are queued by the
// stimulus thread and checked by a monitor whenever hit_tick fires.
module tb_yoshi_ghost_collision;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  yoshi_ghost_collision_if #(.N_GHOSTS(3)) bus ();

  yoshi_ghost_collision #(
    .N_GHOSTS(3), .LIVES(3), .OVERLAP_MIN(16), .INVULN_FRAMES(120), .FLASH_FRAMES(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [2:0] lives;
    logic [2:0] ghost;
    logic       over;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int n, input logic [2:0] g, input logic [9:0] xv, input bit rs);
    bus.i_x        = xv;
    bus.i_y        = 10'd100;
    bus.i_yoshi_on = 1'b1;
    bus.i_ghost_on = g;
    repeat (n) tick();
    bus.i_yoshi_on = 1'b0;
    bus.i_ghost_on = 3'b000;
    bus.i_y        = 10'd480;
    bus.i_restart  = rs;
    tick();
    bus.i_restart  = 1'b0;
    bus.i_y        = 10'd0;
    tick();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && bus.o_hit_tick) begin
      if (q.size() == 0) begin
        check("unexpected_hit_tick", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("hit_lives", int'(bus.o_lives), int'(e.lives));
        check("hit_ghost", int'(bus.o_hit_ghost), int'(e.ghost));
        check("hit_game_over", int'(bus.o_game_over), int'(e.over));
      end
    end
  end

  initial begin
    bus.i_x        = 10'd0;
    bus.i_y        = 10'd0;
    bus.i_yoshi_on = 1'b0;
    bus.i_ghost_on = 3'b000;
    bus.i_restart  = 1'b0;
    repeat (3) tick();
    check("rst_lives", int'(bus.o_lives), 3);
    check("rst_hit_tick", int'(bus.o_hit_tick), 0);
    check("rst_hit_ghost", int'(bus.o_hit_ghost), 0);
    check("rst_visible", int'(bus.o_yoshi_visible), 1);
    check("rst_freeze", int'(bus.o_ghosts_freeze), 0);
    check("rst_game_over", int'(bus.o_game_over), 0);
    reset = 1'b0;
    tick();

    // Off-screen overlap and a 15-cycle overlap must both be ignored
    frame(20, 3'b001, 10'd700, 1'b0);
    frame(15, 3'b001, 10'd100, 1'b0);
    check("lives_after_15", int'(bus.o_lives), 3);

    q.push_back('{lives: 3'd2, ghost: 3'b010, over: 1'b0});
    frame(16, 3'b010, 10'd100, 1'b0);
    check("lives_after_16", int'(bus.o_lives), 2);
    check("hit_ghost_010", int'(bus.o_hit_ghost), 3'b010);
    check("visible_frame0", int'(bus.o_yoshi_visible), 1);

    for (int k = 1; k <= 120; k++) begin
      frame(20, 3'b111, 10'd100, 1'b0);
      check($sformatf("visible_f%0d", k), int'(bus.o_yoshi_visible),
            (k == 120) ? 1 : (((k / 8) % 2 == 0) ? 1 : 0));
    end
    check("lives_after_invuln", int'(bus.o_lives), 2);

    q.push_back('{lives: 3'd1, ghost: 3'b100, over: 1'b0});
    frame(16, 3'b100, 10'd100, 1'b0);
    check("lives_hit2", int'(bus.o_lives), 1);
    for (int k = 0; k < 120; k++) frame(0, 3'b000, 10'd100, 1'b0);

    q.push_back('{lives: 3'd0, ghost: 3'b011, over: 1'b1});
    frame(20, 3'b011, 10'd100, 1'b0);
    check("lives_hit3", int'(bus.o_lives), 0);
    check("game_over", int'(bus.o_game_over), 1);
    check("ghosts_freeze", int'(bus.o_ghosts_freeze), 1);
    check("visible_over", int'(bus.o_yoshi_visible), 1);
    frame(30, 3'b111, 10'd100, 1'b0);
    check("lives_over_hold", int'(bus.o_lives), 0);

    bus.i_restart = 1'b1;
    tick();
    bus.i_restart = 1'b0;
    check("restart_lives", int'(bus.o_lives), 3);
    check("restart_game_over", int'(bus.o_game_over), 0);
    check("restart_freeze", int'(bus.o_ghosts_freeze), 0);
    check("restart_hit_ghost", int'(bus.o_hit_ghost), 0);

    frame(20, 3'b001, 10'd100, 1'b1);
    check("restart_vs_hit_lives", int'(bus.o_lives), 3);
    check("restart_vs_hit_ghost", int'(bus.o_hit_ghost), 0);

    // Park in HIT with 50 frames of invulnerability left, then reset asynchronously
    q.push_back('{lives: 3'd2, ghost: 3'b001, over: 1'b0});
    frame(16, 3'b001, 10'd100, 1'b0);
    for (int k = 0; k < 70; k++) frame(0, 3'b000, 10'd100, 1'b0);
    check("midhit_lives", int'(bus.o_lives), 2);
    #2 reset = 1'b1;
    #1;
    check("async_rst_lives", int'(bus.o_lives), 3);
    check("async_rst_hit_ghost", int'(bus.o_hit_ghost), 0);
    check("async_rst_visible", int'(bus.o_yoshi_visible), 1);
    check("async_rst_game_over", int'(bus.o_game_over), 0);
    check("async_rst_freeze", int'(bus.o_ghosts_freeze), 0);
    #2 reset = 1'b0;
    tick();

    // 512 overlap cycles: a wrapping 9-bit counter would read 0 here
    q.push_back('{lives: 3'd2, ghost: 3'b010, over: 1'b0});
    frame(512, 3'b010, 10'd100, 1'b0);
    check("sat_lives", int'(bus.o_lives), 2);

    repeat (5) tick();
    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
